// File: rtl/moesi_pkg.sv
// Shared MOESI encodings for the requester agent and the home directory:
// line states, request codes, forward codes and the agent FSM states.
package moesi_pkg;

  typedef enum logic [2:0] {
    ST_I = 3'd0,
    ST_S = 3'd1,
    ST_E = 3'd2,
    ST_O = 3'd3,
    ST_M = 3'd4
  } line_st_e;

  typedef enum logic [1:0] {
    REQ_GETS = 2'd0,
    REQ_GETM = 2'd1,
    REQ_UPG  = 2'd2
  } req_e;

  typedef enum logic [1:0] {
    FWD_INV  = 2'd0,
    FWD_GETS = 2'd1,
    FWD_GETM = 2'd2
  } fwd_e;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_REQ  = 2'd1,
    FSM_WAIT = 2'd2,
    FSM_DONE = 2'd3
  } fsm_e;

  function automatic logic is_dirty(input line_st_e st);
    return (st == ST_M) || (st == ST_O);
  endfunction

endpackage

// File: rtl/moesi_line_array.sv
// Per-line MOESI state registers. A forward is applied first; an install in
// the same cycle then overrides it. The CPU lookup sees the post-forward state.
module moesi_line_array
  import moesi_pkg::*;
#(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IDX_W-1:0]       lookup_idx_i,
  output line_st_e               lookup_st_o,
  input  logic                   fwd_en_i,
  input  logic [1:0]             fwd_type_i,
  input  logic [IDX_W-1:0]       fwd_idx_i,
  output line_st_e               fwd_old_st_o,
  input  logic                   install_en_i,
  input  logic [IDX_W-1:0]       install_idx_i,
  input  line_st_e               install_st_i,
  output logic [3*NUM_LINES-1:0] line_state_o
);

  line_st_e state_q [NUM_LINES];
  line_st_e fwd_applied [NUM_LINES];
  line_st_e state_d [NUM_LINES];

  always_comb begin
    fwd_applied  = state_q;
    fwd_old_st_o = state_q[fwd_idx_i];
    if (fwd_en_i) begin
      unique case (fwd_type_i)
        FWD_INV, FWD_GETM: fwd_applied[fwd_idx_i] = ST_I;
        FWD_GETS: begin
          if (state_q[fwd_idx_i] == ST_M)      fwd_applied[fwd_idx_i] = ST_O;
          else if (state_q[fwd_idx_i] == ST_E) fwd_applied[fwd_idx_i] = ST_S;
        end
        default: ;
      endcase
    end
    lookup_st_o = fwd_applied[lookup_idx_i];
    state_d     = fwd_applied;
    if (install_en_i) state_d[install_idx_i] = install_st_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_LINES; k++) state_q[k] <= ST_I;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    line_state_o = '0;
    for (int unsigned k = 0; k < NUM_LINES; k++) line_state_o[3*k +: 3] = state_q[k];
  end

endmodule

// File: rtl/moesi_cache_agent.sv
// Requester-side MOESI agent: CPU op FSM, directory requests, forward handling.
// Optional hit/miss counters are enabled by defining MOESI_AGENT_STATS_EN.
module moesi_cache_agent
  import moesi_pkg::*;
#(
  parameter logic [1:0]  PROC_ID   = 2'd0,
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_valid,
  output logic                   cpu_ready,
  input  logic                   cpu_we,
  input  logic [IDX_W-1:0]       cpu_line,
  output logic                   cpu_done,
  output logic                   cpu_hit,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [1:0]             req_type,
  output logic [IDX_W-1:0]       req_line,
  output logic [1:0]             req_proc,
  input  logic                   resp_valid,
  input  logic [2:0]             resp_state,
  input  logic [IDX_W-1:0]       resp_line,
  input  logic                   fwd_valid,
  output logic                   fwd_ready,
  input  logic [1:0]             fwd_type,
  input  logic [IDX_W-1:0]       fwd_line,
  output logic                   fwd_ack,
  output logic                   fwd_dirty,
  output logic [3*NUM_LINES-1:0] line_state
`ifdef MOESI_AGENT_STATS_EN
  ,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
`endif
);

  fsm_e             fsm_q, fsm_d;
  req_e             type_q, type_d;
  logic [IDX_W-1:0] line_q, line_d;
  logic             hit_q, hit_d;
  logic             fwd_ack_q, fwd_dirty_q;

  line_st_e         lookup_st, fwd_old_st, install_st;
  logic             install_en;
  logic [IDX_W-1:0] install_idx;

  moesi_line_array #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W)
  ) u_lines (
    .clk          (clk),
    .reset        (reset),
    .lookup_idx_i (cpu_line),
    .lookup_st_o  (lookup_st),
    .fwd_en_i     (fwd_valid),
    .fwd_type_i   (fwd_type),
    .fwd_idx_i    (fwd_line),
    .fwd_old_st_o (fwd_old_st),
    .install_en_i (install_en),
    .install_idx_i(install_idx),
    .install_st_i (install_st),
    .line_state_o (line_state)
  );

  always_comb begin
    fsm_d       = fsm_q;
    type_d      = type_q;
    line_d      = line_q;
    hit_d       = hit_q;
    install_en  = 1'b0;
    install_st  = ST_M;
    install_idx = line_q;
    unique case (fsm_q)
      FSM_IDLE: begin
        if (cpu_valid) begin
          line_d      = cpu_line;
          install_idx = cpu_line;
          hit_d       = 1'b1;
          fsm_d       = FSM_DONE;
          // lookup_st already reflects any same-cycle forward on this line
          if (!cpu_we) begin
            if (lookup_st == ST_I) begin
              fsm_d  = FSM_REQ;
              type_d = REQ_GETS;
              hit_d  = 1'b0;
            end
          end else begin
            unique case (lookup_st)
              ST_M: ;
              ST_E: install_en = 1'b1;
              ST_S, ST_O: begin
                fsm_d  = FSM_REQ;
                type_d = REQ_UPG;
                hit_d  = 1'b0;
              end
              default: begin
                fsm_d  = FSM_REQ;
                type_d = REQ_GETM;
                hit_d  = 1'b0;
              end
            endcase
          end
        end
      end
      FSM_REQ: if (req_ready) fsm_d = FSM_WAIT;
      FSM_WAIT: begin
        if (resp_valid && (resp_line == line_q)) begin
          install_en = 1'b1;
          install_st = (type_q == REQ_GETS) ? line_st_e'(resp_state) : ST_M;
          fsm_d      = FSM_DONE;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= FSM_IDLE;
      type_q      <= REQ_GETS;
      line_q      <= '0;
      hit_q       <= 1'b0;
      fwd_ack_q   <= 1'b0;
      fwd_dirty_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      type_q      <= type_d;
      line_q      <= line_d;
      hit_q       <= hit_d;
      fwd_ack_q   <= fwd_valid;
      fwd_dirty_q <= fwd_valid && is_dirty(fwd_old_st);
    end
  end

  assign cpu_ready = (fsm_q == FSM_IDLE);
  assign cpu_done  = (fsm_q == FSM_DONE);
  assign cpu_hit   = (fsm_q == FSM_DONE) && hit_q;
  assign req_valid = (fsm_q == FSM_REQ);
  assign req_type  = type_q;
  assign req_line  = line_q;
  assign req_proc  = PROC_ID;
  assign fwd_ready = 1'b1;
  assign fwd_ack   = fwd_ack_q;
  assign fwd_dirty = fwd_dirty_q;

`ifdef MOESI_AGENT_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (cpu_done) begin
      if (cpu_hit && (hit_cnt_q != '1))         hit_cnt_q  <= hit_cnt_q + 16'd1;
      else if (!cpu_hit && (miss_cnt_q != '1))  miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_moesi_cache_agent.sv
// Directed self-checking bench for moesi_cache_agent (4 lines, PROC_ID=2).
module tb_moesi_cache_agent;
  import moesi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid, cpu_ready, cpu_we, cpu_done, cpu_hit;
  logic [1:0]  cpu_line;
  logic        req_valid, req_ready;
  logic [1:0]  req_type, req_line, req_proc;
  logic        resp_valid;
  logic [2:0]  resp_state;
  logic [1:0]  resp_line;
  logic        fwd_valid, fwd_ready, fwd_ack, fwd_dirty;
  logic [1:0]  fwd_type, fwd_line;
  logic [11:0] line_state;

  int n_assert = 0;
  int n_fail   = 0;

  moesi_cache_agent #(
    .PROC_ID  (2'd2),
    .NUM_LINES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_line(cpu_line),
    .cpu_done(cpu_done), .cpu_hit(cpu_hit),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_line(req_line),
    .req_proc(req_proc),
    .resp_valid(resp_valid), .resp_state(resp_state), .resp_line(resp_line),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_type(fwd_type), .fwd_line(fwd_line),
    .fwd_ack(fwd_ack), .fwd_dirty(fwd_dirty),
    .line_state(line_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full miss transaction with immediate req_ready and response.
  task automatic miss(input logic we, input logic [1:0] line, input logic [2:0] rs,
                      input logic [1:0] exp_type, input logic [2:0] exp_st);
    cpu_valid = 1'b1; cpu_we = we; cpu_line = line;
    tick();
    cpu_valid = 1'b0;
    chk("miss_req_valid", 32'(req_valid), 32'd1);
    chk("miss_req_type", 32'(req_type), 32'(exp_type));
    chk("miss_req_line", 32'(req_line), 32'(line));
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1; resp_state = rs; resp_line = line;
    tick();
    resp_valid = 1'b0;
    chk("miss_done", 32'(cpu_done), 32'd1);
    chk("miss_hit", 32'(cpu_hit), 32'd0);
    chk("miss_state", 32'(line_state[3*line +: 3]), 32'(exp_st));
    tick();
    chk("miss_idle", 32'(cpu_ready), 32'd1);
  endtask

  task automatic cpu_hit_op(input logic we, input logic [1:0] line);
    cpu_valid = 1'b1; cpu_we = we; cpu_line = line;
    tick();
    cpu_valid = 1'b0;
    chk("hit_done", 32'(cpu_done), 32'd1);
    chk("hit_hit", 32'(cpu_hit), 32'd1);
    chk("hit_no_req", 32'(req_valid), 32'd0);
    tick();
  endtask

  task automatic fwd(input logic [1:0] ft, input logic [1:0] line,
                     input logic [2:0] exp_st, input logic exp_dirty);
    fwd_valid = 1'b1; fwd_type = ft; fwd_line = line;
    tick();
    fwd_valid = 1'b0;
    chk("fwd_ack", 32'(fwd_ack), 32'd1);
    chk("fwd_dirty", 32'(fwd_dirty), 32'(exp_dirty));
    chk("fwd_state", 32'(line_state[3*line +: 3]), 32'(exp_st));
    tick();
    chk("fwd_ack_pulse", 32'(fwd_ack), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_valid = 1'b0; cpu_we = 1'b0; cpu_line = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_state = '0; resp_line = '0;
    fwd_valid = 1'b0; fwd_type = '0; fwd_line = '0;
    tick(); tick();
    chk("rst_lines", 32'(line_state), 32'h0);
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_hit", 32'(cpu_hit), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_type", 32'(req_type), 32'd0);
    chk("rst_req_line", 32'(req_line), 32'd0);
    chk("rst_fwd_ack", 32'(fwd_ack), 32'd0);
    chk("rst_fwd_dirty", 32'(fwd_dirty), 32'd0);
    chk("rst_req_proc", 32'(req_proc), 32'd2);
    chk("fwd_ready", 32'(fwd_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Read miss line 0, granted E; then read hit.
    miss(1'b0, 2'd0, 3'd2, 2'd0, 3'd2);
    cpu_hit_op(1'b0, 2'd0);

    // Line 1 to E, then silent write upgrade to M.
    miss(1'b0, 2'd1, 3'd2, 2'd0, 3'd2);
    cpu_hit_op(1'b1, 2'd1);
    chk("silent_upg", 32'(line_state[5:3]), 32'd4);

    // Line 2 to S, write issues UPG held for 3 cycles, granted M.
    miss(1'b0, 2'd2, 3'd1, 2'd0, 3'd1);
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_line = 2'd2;
    tick();
    cpu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("upg_hold_valid", 32'(req_valid), 32'd1);
      chk("upg_hold_type", 32'(req_type), 32'd2);
      chk("upg_hold_line", 32'(req_line), 32'd2);
      chk("upg_hold_proc", 32'(req_proc), 32'd2);
      tick();
    end
    req_ready = 1'b1;
    resp_valid = 1'b1; resp_state = 3'd4; resp_line = 2'd2;
    tick();
    req_ready = 1'b0;
    chk("upg_handshake_no_resp", 32'(cpu_done), 32'd0);
    tick();
    resp_valid = 1'b0;
    chk("upg_done", 32'(cpu_done), 32'd1);
    chk("upg_state", 32'(line_state[8:6]), 32'd4);
    tick();

    // Line 3 via write miss: GETM installs M even if granted E.
    miss(1'b1, 2'd3, 3'd2, 2'd1, 3'd4);
    fwd(2'd1, 2'd3, 3'd3, 1'b1);
    fwd(2'd0, 2'd3, 3'd0, 1'b1);
    // E line under FWD_GETS goes S, clean.
    fwd(2'd1, 2'd0, 3'd1, 1'b0);
    chk("lines_after_fwd", 32'(line_state), 32'(12'o0441));

    // Line 2 M -> O, then write O issues UPG; INV and response collide in WAIT.
    fwd(2'd1, 2'd2, 3'd3, 1'b1);
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_line = 2'd2;
    tick();
    cpu_valid = 1'b0;
    chk("o_write_type", 32'(req_type), 32'd2);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1; resp_state = 3'd4; resp_line = 2'd1;
    tick();
    chk("mismatch_ignored", 32'(cpu_done), 32'd0);
    resp_line = 2'd2;
    fwd_valid = 1'b1; fwd_type = 2'd0; fwd_line = 2'd2;
    tick();
    resp_valid = 1'b0; fwd_valid = 1'b0;
    chk("race_state", 32'(line_state[8:6]), 32'd4);
    chk("race_fwd_ack", 32'(fwd_ack), 32'd1);
    chk("race_fwd_dirty", 32'(fwd_dirty), 32'd1);
    chk("race_done", 32'(cpu_done), 32'd1);
    tick();

    // Reset during REQ drops the request.
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_line = 2'd3;
    tick();
    cpu_valid = 1'b0;
    chk("pre_rst_req", 32'(req_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(req_valid), 32'd0);
    chk("mid_rst_ready", 32'(cpu_ready), 32'd1);
    chk("mid_rst_lines", 32'(line_state), 32'h0);
    tick();
    reset = 1'b0;
    chk("mid_rst_done", 32'(cpu_done), 32'd0);
    tick();
    chk("post_rst_done", 32'(cpu_done), 32'd0);
    chk("post_rst_req", 32'(req_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/moesi_cache_agent.md
# moesi_cache_agent

Requester-side MOESI coherence agent for one processor: the cache controller that issues GetS/GetM/Upgrade requests to the home directory and answers the directory's invalidations and forwards. Sits between a processor's load/store port and the directory, tracks a small direct-indexed set of lines, and exposes their states for observation.

## Interface
- PROC_ID, default 0: 2-bit ID driven on req_proc.
- NUM_LINES, default 4: tracked lines, power of two.
- IDX_W, default $clog2(NUM_LINES): line-index width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_valid  in  1  CPU op request.
- cpu_ready  out  1  agent can accept an op.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_line  in  IDX_W  target line.
- cpu_done  out  1  one-cycle pulse when the op completes.
- cpu_hit  out  1  valid with cpu_done: completed without a directory request.
- req_valid  out  1  directory request valid.
- req_ready  in  1  directory accepts.
- req_type  out  2  0 GETS, 1 GETM, 2 UPG.
- req_line  out  IDX_W  request line.
- req_proc  out  2  equals PROC_ID.
- resp_valid  in  1  grant from directory, always accepted.
- resp_state  in  3  granted state: E, S or M.
- fwd_valid  in  1  directory forward or invalidate.
- fwd_ready  out  1  agent accepts the forward.
- fwd_type  in  2  0 INV, 1 FWD_GETS, 2 FWD_GETM.
- fwd_line  in  IDX_W  forward line.
- fwd_ack  out  1  one-cycle acknowledge pulse.
- fwd_dirty  out  1  valid with fwd_ack: line was M or O.
- line_state  out  3*NUM_LINES  flattened per-line states; line k is in bits [3k+2:3k].

## Operation
- State encoding: I=0, S=1, E=2, O=3, M=4.
- FSM states: IDLE, REQ, WAIT, DONE. cpu_ready is 1 only in IDLE.
- IDLE, CPU op accepted:
  - Read hit on S/E/O/M, or write hit on M: go to DONE with hit=1.
  - Write on E: silent upgrade E->M, go to DONE with hit=1.
  - Write on S/O: go to REQ with type UPG.
  - Read on I: go to REQ with type GETS.
  - Write on I: go to REQ with type GETM.
- REQ: hold req_valid and its fields stable until req_ready, then go to WAIT.
- WAIT: on resp_valid (resp_line equals the pending line), install the grant and go to DONE with hit=0.
  - Read miss installs resp_state.
  - GETM and UPG always install M, whatever resp_state carries.
- DONE: pulse cpu_done and cpu_hit, return to IDLE.
- Forwards: fwd_ready is 1 in every state. Each accepted forward is applied in one cycle, based on the line's old state:
  - INV: line becomes I.
  - FWD_GETS: M->O, E->S; S, O and I are unchanged.
  - FWD_GETM: line becomes I.
  - fwd_dirty = (old state is M or O).
- Same-cycle forward and response on the same line: the forward is applied first, then the response overwrites it, so the response wins.
- Same-cycle forward and CPU acceptance on the same line: the forward is applied first, and the hit/miss decision uses the post-forward state.
- resp_valid outside WAIT, or with a mismatched line, is ignored.

## Timing
- Reset values:
  - All lines I.
  - FSM IDLE, so cpu_ready=1.
  - cpu_done, cpu_hit, req_valid, req_type, req_line, fwd_ack and fwd_dirty all 0.
  - req_proc=PROC_ID.
- Hit accepted at cycle N: cpu_done at N+1.
- Miss accepted at cycle N:
  - req_valid rises at N+1.
  - A response can be taken from the cycle after the req handshake onward; it is never taken in the handshake cycle itself.
  - cpu_done comes 1 cycle after the response.
- Forward handshake at cycle N: fwd_ack and fwd_dirty are registered at N+1. line_state is updated at N+1.
- Reset asserted mid-operation drops any outstanding request immediately, with no pulse emitted.

## Configuration
- MOESI_AGENT_STATS_EN defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0], both reset to 0.
  - They count completed ops by cpu_hit and saturate at 16'hFFFF.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package moesi_pkg holds:
  - State encodings I/S/E/O/M.
  - Request codes GETS/GETM/UPG.
  - Forward codes INV/FWD_GETS/FWD_GETM.
  - FSM state encoding.
- The directory uses the same package.
- One sub-module, moesi_line_array: per-line state registers. It has a CPU lookup read port, a forward read-modify-write port, and a response install port, and applies the ordering rule "forward first, response overrides".

## Test plan
- Read line 0 from reset -> GETS issued. Respond E: line_state[2:0]=2, cpu_done with cpu_hit=0. Reading again gives cpu_done 1 cycle later with hit=1 and no req_valid.
- Line 1 in E, write -> no request, line becomes M (4), cpu_hit=1.
- Line 2 in S, write -> UPG issued. Hold req_ready low for 3 cycles and check req_fields stay stable. Respond M: line 2 becomes 4.
- Line 3 in M, FWD_GETS -> line becomes O (3), fwd_ack=1 and fwd_dirty=1. Then INV -> line becomes I, fwd_dirty=1.
- While in WAIT for UPG on line 2, INV on line 2 and resp in the same cycle -> final state M, fwd_ack pulses, cpu_done pulses.
- Assert reset while in REQ -> all lines I, req_valid=0, cpu_ready=1, no cpu_done pulse.
